fm_step_sequencer: RTL and testbench

- Controller that sequences frequency-step updates into the FM NCO phase accumulator.
- Accepts distance samples over a valid/ready handshake and reads the distance-to-frequency-step ROM through its registered read port.
- Slews the NCO frequency step toward the new target, at most MAX_SLEW per update tick, so the FM output never jumps in frequency.
- Sits between the distance source (ADC averaging path) and the phase accumulator; its freq_step output drives the accumulator increment directly.

---
 rtl/fm_step_sequencer_if.sv | 22 ++
 rtl/fm_step_sequencer.sv | 91 +++++++++
 tb/tb_fm_step_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fm_step_sequencer_if.sv
// fm_step_sequencer_if: distance handshake and ROM read-port bundle for the FM step sequencer
interface fm_step_sequencer_if #(
    parameter int WIDTH       = 13,
    parameter int PHASE_WIDTH = 32
);
    logic                   dist_valid;
    logic                   dist_ready;
    logic [WIDTH-1:0]       distance;
    logic                   lut_rd;
    logic [WIDTH-1:0]       lut_addr;
    logic [PHASE_WIDTH-1:0] lut_data;

    modport master (
        output dist_valid, distance, lut_data,
        input  dist_ready, lut_rd, lut_addr
    );

    modport slave (
        input  dist_valid, distance, lut_data,
        output dist_ready, lut_rd, lut_addr
    );
endinterface

// File: rtl/fm_step_sequencer.sv
// fm_step_sequencer: looks up a target NCO step per distance sample and slews freq_step toward it
module fm_step_sequencer #(
    parameter int                     WIDTH       = 13,
    parameter int                     PHASE_WIDTH = 32,
    parameter int                     MAX_DIST    = 2000,
    parameter int                     LUT_LATENCY = 2,
    parameter int                     TICK_DIV    = 4,
    parameter logic [PHASE_WIDTH-1:0] MAX_SLEW    = 32'h0100_0000,
    parameter logic [PHASE_WIDTH-1:0] RESET_STEP  = 32'h3333_3333
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    fm_step_sequencer_if.slave      bus,
    output logic [PHASE_WIDTH-1:0]  freq_step,
    output logic                    busy,
    output logic                    settled
);
    typedef enum logic [1:0] {IDLE, LOOKUP, SLEW} state_t;

    localparam logic [WIDTH-1:0] MAX_ADDR = WIDTH'(MAX_DIST);
    localparam logic [2:0]       LAT      = 3'(LUT_LATENCY);
    localparam logic [15:0]      TICK_MAX = 16'(TICK_DIV - 1);

    state_t                 state, state_n;
    logic [PHASE_WIDTH-1:0] target, target_n, step_n, diff, slewed;
    logic [WIDTH-1:0]       addr_q, addr_n, clamped;
    logic [2:0]             wait_q, wait_n;
    logic [15:0]            tick_q;
    logic                   lut_rd_q, lut_rd_n, tick, accept, done;

    assign tick           = enable && (tick_q == TICK_MAX);
    assign bus.dist_ready = enable && (state == IDLE || state == SLEW);
    assign accept         = bus.dist_valid && bus.dist_ready;
    assign bus.lut_rd     = lut_rd_q && enable;
    assign bus.lut_addr   = addr_q;
    assign clamped        = (bus.distance > MAX_ADDR) ? MAX_ADDR : bus.distance;
    assign diff           = (target >= freq_step) ? target - freq_step : freq_step - target;
    assign done           = (MAX_SLEW == '0) || (diff <= MAX_SLEW);
    assign slewed         = done ? target : (target > freq_step) ? freq_step + MAX_SLEW : freq_step - MAX_SLEW;
    assign busy           = state != IDLE;
    assign settled        = (state == IDLE) && (freq_step == target);

    // next state: capture the ROM word after the read latency, apply slew on ticks, a new sample restarts the lookup
    always_comb begin
        state_n  = state;
        step_n   = freq_step;
        target_n = target;
        lut_rd_n = 1'b0;
        addr_n   = addr_q;
        wait_n   = wait_q;
        if (state == LOOKUP) begin
            wait_n = wait_q + 3'd1;
            if (wait_q == LAT) begin
                target_n = bus.lut_data;
                state_n  = (bus.lut_data == freq_step) ? IDLE : SLEW;
            end
        end
        if (state == SLEW && tick) begin
            step_n  = slewed;
            state_n = done ? IDLE : SLEW;
        end
        if (accept) begin
            addr_n   = clamped;
            lut_rd_n = 1'b1;
            wait_n   = '0;
            state_n  = LOOKUP;
        end
    end

    // state, step and free-running tick counter; everything holds while enable is low
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            freq_step <= RESET_STEP;
            target    <= RESET_STEP;
            lut_rd_q  <= 1'b0;
            addr_q    <= '0;
            wait_q    <= '0;
            tick_q    <= '0;
        end else if (enable) begin
            state     <= state_n;
            freq_step <= step_n;
            target    <= target_n;
            lut_rd_q  <= lut_rd_n;
            addr_q    <= addr_n;
            wait_q    <= wait_n;
            tick_q    <= tick ? '0 : tick_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_fm_step_sequencer.sv
// tb_fm_step_sequencer: scoreboard bench with a behavioural slew model and a latency-accurate ROM
module tb_fm_step_sequencer;
    localparam int          W        = 13;
    localparam int          PW       = 32;
    localparam int          MAX_DIST = 2000;
    localparam int          L        = 2;
    localparam int          TD       = 4;
    localparam logic [31:0] MS       = 32'h0100_0000;
    localparam logic [31:0] RS       = 32'h3333_3333;

    typedef struct {logic [31:0] v; int t;} ev_t;

    logic        clk = 1'b0;
    logic        reset, enable, busy, settled;
    logic [31:0] freq_step;

    fm_step_sequencer_if #(.WIDTH(W), .PHASE_WIDTH(PW)) bus();

    fm_step_sequencer #(
        .WIDTH(W), .PHASE_WIDTH(PW), .MAX_DIST(MAX_DIST), .LUT_LATENCY(L),
        .TICK_DIV(TD), .MAX_SLEW(MS), .RESET_STEP(RS)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus),
        .freq_step(freq_step), .busy(busy), .settled(settled)
    );

    always #5 clk = ~clk;

    logic [31:0]   rom_tbl [0:MAX_DIST];
    ev_t           lut_q[$];
    ev_t           step_q[$];
    ev_t           ev;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   m_step = RS;
    logic [31:0]   m_target = RS;
    logic [W-1:0]  m_addr = '0;
    int            m_cnt = 0;
    bit            m_slew = 0;
    int            m_tick = 0;
    int            en_cyc = 0;
    bit            mon_on = 0;
    logic [31:0]   prev_fs = RS;
    logic [W-1:0]  rom_addr;
    int            rom_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (enabled cycle %0d)", name, act, exp, en_cyc);
        end
    endtask

    // ROM with a registered read port: a wrong word is shown until the true word is due
    always @(posedge clk) begin
        if (enable) begin
            if (bus.lut_rd) begin
                rom_addr     <= bus.lut_addr;
                rom_cnt      <= L - 1;
                bus.lut_data <= (L == 1) ? rom_tbl[bus.lut_addr] : ~rom_tbl[bus.lut_addr];
            end else if (rom_cnt > 0) begin
                rom_cnt <= rom_cnt - 1;
                if (rom_cnt == 1) bus.lut_data <= rom_tbl[rom_addr];
            end
        end
    end

    // reference model: one call per clock edge with the inputs the DUT sampled on it
    task automatic model_edge(input bit r, input bit e, input bit v, input logic [W-1:0] d);
        logic [31:0] prev, diff;
        bit          tick, acc;
        prev = m_step;
        if (r) begin
            m_step = RS; m_target = RS; m_cnt = 0; m_slew = 0; m_tick = 0; en_cyc = 0;
            if (prev != RS) step_q.push_back('{RS, 0});
            return;
        end
        if (!e) return;
        en_cyc++;
        acc  = v && (m_cnt == 0);
        tick = (m_tick == TD - 1);
        if (m_slew && tick) begin
            diff = (m_target > m_step) ? m_target - m_step : m_step - m_target;
            if (MS == 0 || diff <= MS) begin
                m_step = m_target;
                m_slew = 0;
            end else begin
                m_step = (m_target > m_step) ? m_step + MS : m_step - MS;
            end
        end
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_target = rom_tbl[m_addr];
                m_slew   = (m_target != m_step);
            end
        end
        if (acc) begin
            m_addr = (d > W'(MAX_DIST)) ? W'(MAX_DIST) : d;
            lut_q.push_back('{32'(m_addr), en_cyc});
            m_cnt  = L + 1;
            m_slew = 0;
        end
        m_tick = (m_tick + 1) % TD;
        if (m_step != prev) step_q.push_back('{m_step, en_cyc});
    endtask

    task automatic cyc(input bit r, input bit e, input bit v, input logic [W-1:0] d);
        reset          = r;
        enable         = e;
        bus.dist_valid = v;
        bus.distance   = d;
        @(posedge clk);
        model_edge(r, e, v, d);
        #1;
    endtask

    task automatic wait_settle();
        for (int k = 0; k < 3000 && (m_cnt > 0 || m_slew); k++) cyc(0, 1, 0, '0);
    endtask

    task automatic wait_step(input logic [31:0] s);
        for (int k = 0; k < 1000 && m_step != s; k++) cyc(0, 1, 0, '0);
    endtask

    // monitor: pops expected ROM reads and step changes as the DUT presents them
    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            if (bus.lut_rd) begin
                if (lut_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL lut_rd: unexpected read of addr %0d, none required", bus.lut_addr);
                end else begin
                    ev = lut_q.pop_front();
                    check("lut_addr", 32'(bus.lut_addr), ev.v);
                    check("lut_rd_cycle", 32'(en_cyc), 32'(ev.t));
                end
            end
            if (freq_step !== prev_fs) begin
                if (step_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL freq_step_change: got %h, no change required", freq_step);
                end else begin
                    ev = step_q.pop_front();
                    check("freq_step_change", freq_step, ev.v);
                    check("freq_step_cycle", 32'(en_cyc), 32'(ev.t));
                end
                prev_fs = freq_step;
            end
            check("freq_step", freq_step, m_step);
            check("ready_busy_settled", {29'b0, bus.dist_ready, busy, settled},
                  {29'b0, enable && m_cnt == 0, m_cnt > 0 || m_slew, m_cnt == 0 && !m_slew && m_step == m_target});
        end
    end

    initial begin
        for (int i = 0; i <= MAX_DIST; i++)
            rom_tbl[i] = (i % 97 == 0) ? ((i % 2 == 0) ? 32'h0000_0100 : 32'hFFFF_FF00)
                                       : RS + $urandom_range(0, 32'h0A00_0000) - 32'h0500_0000;
        rom_tbl[100]      = 32'h3633_3333;
        rom_tbl[MAX_DIST] = RS;
        rom_tbl[50]       = 32'h3233_3333;
        cyc(1, 1, 0, '0);
        mon_on = 1;
        repeat (20) cyc(0, 1, 0, '0);
        cyc(0, 1, 1, 13'd100);
        wait_settle();
        cyc(0, 1, 1, 13'd5000);
        wait_settle();
        repeat (3) cyc(0, 1, 0, '0);
        cyc(0, 1, 1, 13'd100);
        wait_step(32'h3433_3333);
        cyc(0, 1, 1, 13'd50);
        cyc(0, 1, 0, '0);
        repeat (10) cyc(0, 0, 1, 13'd7);
        for (int k = 0; k < 20 && !m_slew; k++) cyc(0, 1, 0, '0);
        repeat (2) cyc(0, 1, 0, '0);
        repeat (10) cyc(0, 0, 1, 13'd9);
        wait_settle();
        cyc(0, 1, 1, 13'd100);
        wait_step(32'h3433_3333);
        cyc(1, 1, 0, '0);
        repeat (8) cyc(0, 1, 0, '0);
        repeat (4000) begin
            automatic bit r = ($urandom_range(0, 999) == 0);
            automatic bit e = r || ($urandom_range(0, 9) != 0);
            automatic bit v = ($urandom_range(0, 19) == 0);
            automatic logic [W-1:0] d = ($urandom_range(0, 9) == 0) ? W'($urandom_range(2001, 8191))
                                                                    : W'($urandom_range(0, MAX_DIST));
            cyc(r, e, v, d);
        end
        wait_settle();
        repeat (3) cyc(0, 1, 0, '0);
        check("lut_queue_drained", 32'(lut_q.size()), 32'd0);
        check("step_queue_drained", 32'(step_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
